fp_sub_arbiter: RTL and testbench

Shares the single FP32 `subtraction` unit among N_REQ requesters, such as audio channel pipelines.
- Arbitrates round-robin, latches the winner's operands and exception flags, and drives the unit's `available`/`done` handshake.
- Returns the result, tagged by requester, as a one-cycle response pulse.
- A watchdog aborts operations that never reach `done` (for example, operands with exception flags set) and reports an error.

---
 rtl/fp_sub_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/fp_sub_arbiter.sv | 156 +++++++++++++++
 tb/tb_fp_sub_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sub_pkg.sv
// Shared types and constants for the FP32 subtraction-unit arbiter.
package fp_sub_pkg;
    localparam int FP_W            = 32;
    localparam int FLAG_W          = 5;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        RUN     = 2'd2,
        RECOVER = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);
    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_sub_arbiter.sv
// Shares one FP32 subtraction unit among N_REQ requesters with round-robin
// arbitration, tagged one-cycle responses and a watchdog abort.
module fp_sub_arbiter
    import fp_sub_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [FP_W*N_REQ-1:0]    a_in,
    input  logic [FP_W*N_REQ-1:0]    b_in,
    input  logic [FLAG_W*N_REQ-1:0]  flag_a_in,
    input  logic [FLAG_W*N_REQ-1:0]  flag_b_in,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [FP_W-1:0]          rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [FP_W-1:0]          sub_a,
    output logic [FP_W-1:0]          sub_b,
    output logic [FLAG_W-1:0]        sub_flag_a,
    output logic [FLAG_W-1:0]        sub_flag_b,
    output logic                     sub_available,
    input  logic [FP_W-1:0]          sub_out,
    input  logic                     sub_done,
    input  logic                     sub_status
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [N_REQ-1:0]   owner_oh;
    logic [CNT_W-1:0]   wdog;
    logic [FP_W-1:0]    a_q;
    logic [FP_W-1:0]    b_q;
    logic [FLAG_W-1:0]  fa_q;
    logic [FLAG_W-1:0]  fb_q;

    logic [N_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               wdog_expired;

    logic [FP_W-1:0]    a_arr  [N_REQ];
    logic [FP_W-1:0]    b_arr  [N_REQ];
    logic [FLAG_W-1:0]  fa_arr [N_REQ];
    logic [FLAG_W-1:0]  fb_arr [N_REQ];

    // The unit's busy level is monitor-only; control relies on sub_done and the watchdog.
    logic unused_status;
    assign unused_status = sub_status;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g]  = a_in[g*FP_W +: FP_W];
        assign b_arr[g]  = b_in[g*FP_W +: FP_W];
        assign fa_arr[g] = flag_a_in[g*FLAG_W +: FLAG_W];
        assign fb_arr[g] = flag_b_in[g*FLAG_W +: FLAG_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req),
        .ptr       (ptr),
        .grant     (win_oh),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    assign wdog_expired = (wdog == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_any) state_next = LAUNCH;
            LAUNCH:  state_next = RUN;
            RUN:     if (sub_done || wdog_expired) state_next = RECOVER;
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are frozen at the grant edge so requesters may drop req right after gnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            owner_oh <= '0;
            wdog     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        a_q      <= a_arr[win_idx];
                        b_q      <= b_arr[win_idx];
                        fa_q     <= fa_arr[win_idx];
                        fb_q     <= fb_arr[win_idx];
                        owner    <= win_idx;
                        owner_oh <= win_oh;
                    end
                end
                LAUNCH: wdog <= '0;
                RUN: begin
                    wdog <= wdog + CNT_W'(1);
                    if (sub_done) begin
                        rsp_data <= sub_out;
                        rsp_err  <= 1'b0;
                    end else if (wdog_expired) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RECOVER: ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt           = '0;
        rsp_valid     = '0;
        sub_available = 1'b0;
        busy          = (state != IDLE);
        case (state)
            LAUNCH: begin
                gnt           = owner_oh;
                sub_available = 1'b1;
            end
            RUN:     sub_available = 1'b1;
            RECOVER: rsp_valid     = owner_oh;
            default: ;
        endcase
    end

    assign sub_a      = a_q;
    assign sub_b      = b_q;
    assign sub_flag_a = fa_q;
    assign sub_flag_b = fb_q;
endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Self-checking bench for fp_sub_arbiter with a behavioural subtraction-unit model.
module tb_fp_sub_arbiter;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req;
    logic [32*N_REQ-1:0]  a_in, b_in;
    logic [5*N_REQ-1:0]   flag_a_in, flag_b_in;
    logic [N_REQ-1:0]     gnt, rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_err, busy;
    logic [31:0]          sub_a, sub_b, sub_out;
    logic [4:0]           sub_flag_a, sub_flag_b;
    logic                 sub_available, sub_done, sub_status;

    int total = 0;
    int bad   = 0;

    fp_sub_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .flag_a_in(flag_a_in), .flag_b_in(flag_b_in), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .sub_a(sub_a), .sub_b(sub_b), .sub_flag_a(sub_flag_a), .sub_flag_b(sub_flag_b),
        .sub_available(sub_available), .sub_out(sub_out), .sub_done(sub_done),
        .sub_status(sub_status)
    );

    always #5 clk = ~clk;

    // Unit model: done after unit_lat cycles of available, never if any flag is set.
    int unit_cnt = 0;
    int unit_lat = 4;

    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == b) return 32'h0;
        if (a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        return a - b;
    endfunction

    always @(posedge clk) begin
        if (!sub_available) unit_cnt <= 0;
        else                unit_cnt <= unit_cnt + 1;
    end

    assign sub_done   = sub_available && (sub_flag_a == 5'd0) && (sub_flag_b == 5'd0)
                        && (unit_cnt >= unit_lat);
    assign sub_out    = sub_done ? unit_fn(sub_a, sub_b) : 32'hDEAD_BEEF;
    assign sub_status = sub_available && !sub_done;

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
        for (int k = 0; k < N_REQ; k++)
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        return -1;
    endfunction

    typedef struct {
        int          idx;
        logic [31:0] a, b;
        logic [4:0]  fa, fb;
        int          lat;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_edges;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] fa, input logic [4:0] fb);
        a_in[idx*32 +: 32]     = a;
        b_in[idx*32 +: 32]     = b;
        flag_a_in[idx*5 +: 5]  = fa;
        flag_b_in[idx*5 +: 5]  = fb;
        req[idx]               = 1'b1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic runVector(input vec_t v);
        int edges;
        bit seen;
        unit_lat = v.lat;
        applyStimulus(v.idx, v.a, v.b, v.fa, v.fb);
        tick();
        edges = 1;
        checkOutput("vec_gnt", gnt, 32'(1) << v.idx);
        checkOutput("vec_avail", sub_available, 1);
        checkOutput("vec_sub_a", sub_a, v.a);
        req[v.idx] = 1'b0;
        seen = 0;
        while (!seen && edges < TIMEOUT + 20) begin
            tick();
            edges++;
            if (rsp_valid != 0) seen = 1;
        end
        checkOutput("vec_rsp_seen", seen, 1);
        if (seen) begin
            checkOutput("vec_rsp_valid", rsp_valid, 32'(1) << v.idx);
            checkOutput("vec_rsp_data", rsp_data, v.exp_data);
            checkOutput("vec_rsp_err", rsp_err, v.exp_err);
            checkOutput("vec_latency", edges, v.exp_edges);
        end
        tick();
        checkOutput("vec_hold_data", rsp_data, v.exp_data);
        checkOutput("vec_idle_valid", rsp_valid, 0);
        checkOutput("vec_idle_busy", busy, 0);
    endtask

    int          exp_order[5] = '{0, 1, 2, 3, 0};
    int          order[$];
    int          n_rsp, n_gnt, gi, stray, w, ptr_m, gnt_cyc, in_idx, in_lat;
    bit          inflight, hang;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_fa, in_fb;
    vec_t        pre;

    initial begin
        rst = 1'b1;
        req = '0;
        a_in = '0; b_in = '0; flag_a_in = '0; flag_b_in = '0;
        repeat (3) tick();
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_avail", sub_available, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_sub_a", sub_a, 0);
        rst = 1'b0;
        tick();

        // idx, a, b, flag_a, flag_b, unit latency, data, err, edges from req to rsp_valid
        vecs[0] = '{0, 32'h4040_0000, 32'h3F80_0000, 5'd0, 5'd0, 4, 32'h4000_0000, 1'b0, 6};
        vecs[1] = '{2, 32'h3F80_0000, 32'h3F80_0000, 5'd0, 5'd0, 4, 32'h0000_0000, 1'b0, 6};
        vecs[2] = '{1, 32'h3F80_0000, 32'h4000_0000, 5'b00001, 5'd0, 4, 32'h0, 1'b1, TIMEOUT + 2};
        vecs[3] = '{3, 32'h1234_5678, 32'h0000_0001, 5'd0, 5'd0, TIMEOUT, 32'h1234_5677, 1'b0, TIMEOUT + 2};
        vecs[4] = '{0, 32'h40A0_0000, 32'h3F80_0000, 5'd0, 5'd0, TIMEOUT + 1, 32'h0, 1'b1, TIMEOUT + 2};
        vecs[5] = '{1, 32'h3F80_0000, 32'h3F80_0000, 5'd0, 5'b10000, 2, 32'h0, 1'b1, TIMEOUT + 2};
        vecs[6] = '{3, 32'h0000_0100, 32'h0000_0001, 5'd0, 5'd0, 1, 32'h0000_00FF, 1'b0, 3};
        for (int i = 0; i < 7; i++) runVector(vecs[i]);

        // Fairness: all requesters held, grants must rotate 0,1,2,3,0.
        pulseReset();
        unit_lat = 3;
        for (int i = 0; i < N_REQ; i++)
            applyStimulus(i, 32'h4000_0000 + 32'(i), 32'h3F80_0000, 5'd0, 5'd0);
        n_rsp = 0;
        for (int c = 0; c < 120 && n_rsp < 5; c++) begin
            tick();
            if (rsp_valid != 0) begin
                checkOutput("fair_rsp_owner", rsp_valid, 32'(1) << exp_order[n_rsp]);
                checkOutput("fair_rsp_data", rsp_data, 32'h0080_0000 + 32'(exp_order[n_rsp]));
                n_rsp++;
            end
            if (gnt != 0) begin
                gi = -1;
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) gi = i;
                order.push_back(gi);
                if (order.size() == 5) req = '0;
            end
        end
        req = '0;
        checkOutput("fair_rsp_count", n_rsp, 5);
        checkOutput("fair_gnt_count", order.size(), 5);
        for (int k = 0; k < order.size() && k < 5; k++)
            checkOutput("fair_order", order[k], exp_order[k]);
        for (int c = 0; c < 20 && busy; c++) tick();

        // Reset in the second RUN cycle; pointer must be back at 0 afterwards.
        pre = '{1, 32'h0000_0010, 32'h0000_0003, 5'd0, 5'd0, 2, 32'h0000_000D, 1'b0, 4};
        runVector(pre);
        unit_lat = 10;
        applyStimulus(2, 32'h3F80_0000, 32'h0000_0001, 5'd0, 5'd0);
        tick();
        checkOutput("mid_gnt", gnt, 32'h4);
        req[2] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_avail", sub_available, 0);
        checkOutput("mid_rsp_valid", rsp_valid, 0);
        stray = 0;
        repeat (15) begin
            tick();
            if (rsp_valid != 0) stray++;
        end
        checkOutput("mid_no_rsp", stray, 0);
        unit_lat = 2;
        applyStimulus(0, 32'h0000_0020, 32'h0000_0001, 5'd0, 5'd0);
        applyStimulus(3, 32'h0000_0030, 32'h0000_0001, 5'd0, 5'd0);
        tick();
        checkOutput("post_rst_gnt_first", gnt, 32'h1);
        req[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt != 0) break;
        end
        checkOutput("post_rst_gnt_second", gnt, 32'h8);
        req[3] = 1'b0;
        for (int c = 0; c < 20 && busy; c++) tick();

        // Randomized traffic against a round-robin reference model.
        pulseReset();
        ptr_m = 0; inflight = 0; n_gnt = 0; n_rsp = 0; in_idx = 0; gnt_cyc = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            if (gnt != 0) begin
                w = rr_pick(req, ptr_m);
                checkOutput("rand_gnt", gnt, (w < 0) ? 32'h0 : (32'(1) << w));
                checkOutput("rand_overlap", inflight, 0);
                in_idx = (w < 0) ? 0 : w;
                in_a   = a_in[in_idx*32 +: 32];
                in_b   = b_in[in_idx*32 +: 32];
                in_fa  = flag_a_in[in_idx*5 +: 5];
                in_fb  = flag_b_in[in_idx*5 +: 5];
                checkOutput("rand_sub_a", sub_a, in_a);
                checkOutput("rand_sub_flag_a", sub_flag_a, in_fa);
                in_lat   = ($urandom_range(0, 9) == 0) ? TIMEOUT + 5 : $urandom_range(1, 6);
                unit_lat = in_lat;
                req[in_idx] = 1'b0;
                inflight = 1;
                gnt_cyc  = cyc;
                n_gnt++;
            end
            if (rsp_valid != 0) begin
                checkOutput("rand_rsp_expected", inflight, 1);
                if (inflight) begin
                    hang = (in_fa != 0) || (in_fb != 0) || (in_lat > TIMEOUT);
                    checkOutput("rand_rsp_owner", rsp_valid, 32'(1) << in_idx);
                    checkOutput("rand_rsp_err", rsp_err, hang);
                    checkOutput("rand_rsp_data", rsp_data, hang ? 32'h0 : unit_fn(in_a, in_b));
                    checkOutput("rand_latency", cyc - gnt_cyc, (hang ? TIMEOUT : in_lat) + 1);
                    ptr_m = (in_idx + 1) % N_REQ;
                    inflight = 0;
                    n_rsp++;
                end
            end else if (inflight && (cyc - gnt_cyc > TIMEOUT + 8)) begin
                checkOutput("rand_rsp_timeout", rsp_valid, 32'(1) << in_idx);
                inflight = 0;
            end
            if (cyc == 1400) req = '0;
            if (cyc < 1400) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!req[i] && !(inflight && in_idx == i) && $urandom_range(0, 3) == 0)
                        applyStimulus(i, $urandom, $urandom,
                                      ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                                      ($urandom_range(0, 14) == 0) ? 5'd16 : 5'd0);
                end
            end
        end
        checkOutput("rand_rsp_count", n_rsp, n_gnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
